// File: rtl/pipe_chain.sv
// rtl/pipe_chain.sv - parametrised in-order valid/allowin pipeline chain with per-stage stall and flush
// Optional feature: define PIPE_PERF_CNT_EN to add per-stage stall counters (perf_stall_cnt).
module pipe_chain #(
    parameter int STAGES = 4,
    parameter int BUS_WD = 64
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [BUS_WD-1:0]        in_bus,
    output logic                     in_allowin,
    output logic [STAGES-1:0]        stg_valid,
    output logic [STAGES*BUS_WD-1:0] stg_bus,
    input  logic [STAGES-1:0]        stg_ready_go,
    input  logic [STAGES*BUS_WD-1:0] stg_out_bus,
    input  logic [STAGES-1:0]        stg_flush,
    output logic                     out_valid,
    output logic [BUS_WD-1:0]        out_bus,
    input  logic                     out_allowin
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [STAGES*32-1:0]     perf_stall_cnt
`endif
);

    logic [STAGES-1:0]        r_valid;
    logic [STAGES*BUS_WD-1:0] r_bus;

    logic [STAGES:0]          w_allowin;
    logic [STAGES-1:0]        w_to_next;
    logic [STAGES-1:0]        w_kill;
    logic [STAGES-1:0]        w_fwd_valid;
    logic [STAGES-1:0]        w_fwd_load;
    logic [STAGES*BUS_WD-1:0] w_fwd_bus;
    logic                     w_flush_any;

    // Handshake network: allowin ripples from the output back to the input,
    // kill accumulates from the oldest stage toward the youngest.
    always_comb begin
        w_allowin   = '0;
        w_to_next   = '0;
        w_kill      = '0;
        w_fwd_valid = '0;
        w_fwd_load  = '0;
        w_fwd_bus   = '0;
        w_flush_any = |stg_flush;

        w_allowin[STAGES] = out_allowin;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_to_next[i] = r_valid[i] && stg_ready_go[i];
            w_allowin[i] = !r_valid[i] || (stg_ready_go[i] && w_allowin[i+1]);
        end

        for (int i = STAGES - 2; i >= 0; i--) begin
            w_kill[i] = w_kill[i+1] | stg_flush[i+1];
        end

        w_fwd_valid[0]         = in_valid && !w_flush_any;
        w_fwd_load[0]          = w_allowin[0] && in_valid && !w_flush_any;
        w_fwd_bus[0 +: BUS_WD] = in_bus;
        for (int i = 1; i < STAGES; i++) begin
            // An entry leaving a killed stage is dropped on the way: it never becomes
            // valid in the next stage, even when that next stage is the flusher itself.
            w_fwd_valid[i]                  = w_to_next[i-1] && !w_kill[i-1];
            w_fwd_load[i]                   = w_allowin[i] && w_to_next[i-1];
            w_fwd_bus[i*BUS_WD +: BUS_WD]   = stg_out_bus[(i-1)*BUS_WD +: BUS_WD];
        end
    end

    // Stage registers: kill beats advance beats hold; the bus is never cleared by kill.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= '0;
            r_bus   <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_kill[i]) begin
                    r_valid[i] <= 1'b0;
                end else if (w_allowin[i]) begin
                    r_valid[i] <= w_fwd_valid[i];
                end
                if (w_fwd_load[i]) begin
                    r_bus[i*BUS_WD +: BUS_WD] <= w_fwd_bus[i*BUS_WD +: BUS_WD];
                end
            end
        end
    end

    assign stg_valid  = r_valid;
    assign stg_bus    = r_bus;
    assign in_allowin = w_allowin[0] && !w_flush_any;
    assign out_valid  = w_to_next[STAGES-1];
    assign out_bus    = stg_out_bus[(STAGES-1)*BUS_WD +: BUS_WD];

`ifdef PIPE_PERF_CNT_EN
    logic [STAGES*32-1:0] r_perf;

    // Stall counters: a valid stage that cannot hand its entry on this cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (r_valid[i] && !(stg_ready_go[i] && w_allowin[i+1])) begin
                    r_perf[i*32 +: 32] <= r_perf[i*32 +: 32] + 32'd1;
                end
            end
        end
    end

    assign perf_stall_cnt = r_perf;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// tb/tb_pipe_chain.sv - randomized and directed self-checking bench for pipe_chain
module tb_pipe_chain;

    localparam int S = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_bus = '0;
    wire            in_allowin;
    wire  [S-1:0]   stg_valid;
    wire  [S*W-1:0] stg_bus;
    logic [S-1:0]   rg = '1;
    logic [S-1:0]   fl = '0;
    wire  [S*W-1:0] stg_out_bus;
    wire            out_valid;
    wire  [W-1:0]   out_bus;
    logic           out_allowin = 1'b1;
`ifdef PIPE_PERF_CNT_EN
    wire  [S*32-1:0] perf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    assign stg_out_bus = stg_bus;

    pipe_chain #(.STAGES(S), .BUS_WD(W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_bus       (in_bus),
        .in_allowin   (in_allowin),
        .stg_valid    (stg_valid),
        .stg_bus      (stg_bus),
        .stg_ready_go (rg),
        .stg_out_bus  (stg_out_bus),
        .stg_flush    (fl),
        .out_valid    (out_valid),
        .out_bus      (out_bus),
        .out_allowin  (out_allowin)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slots holding entries, moved oldest-first each cycle.
    bit        m_v[S];
    bit [31:0] m_d[S];

    // A slot is free this cycle if empty or if its entry departs into a free slot.
    function automatic logic [S:0] model_free();
        logic [S:0] f;
        f[S] = out_allowin;
        for (int i = S - 1; i >= 0; i--) f[i] = !m_v[i] || (rg[i] && f[i+1]);
        return f;
    endfunction

    function automatic void model_step();
        logic [S:0] f;
        bit         leaves[S];
        bit         nv[S];
        bit [31:0]  nd[S];
        bit         arrive;
        bit         dropped;
        f = model_free();
        for (int i = 0; i < S; i++) leaves[i] = m_v[i] && rg[i] && f[i+1];
        for (int i = 0; i < S; i++) begin
            nv[i] = m_v[i];
            nd[i] = m_d[i];
            arrive  = (i == 0) ? (in_valid && fl == 0) : leaves[i-1];
            dropped = (i == 0) ? 1'b0 : ((fl >> i) != 0);
            if (f[i]) begin
                nv[i] = arrive && !dropped;
                if (arrive) nd[i] = (i == 0) ? in_bus : m_d[i-1];
            end
            if ((fl >> (i + 1)) != 0) nv[i] = 1'b0;
        end
        for (int i = 0; i < S; i++) begin
            m_v[i] = nv[i];
            m_d[i] = nd[i];
        end
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < S; i++) begin
                m_v[i] = 1'b0;
                m_d[i] = '0;
            end
        end else begin
            model_step();
        end
    end

    logic [S:0]   cmp_f;
    logic [S-1:0] cmp_v;

    // Cycle-by-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (resetn) begin
            cmp_f = model_free();
            for (int i = 0; i < S; i++) cmp_v[i] = m_v[i];
            check("stg_valid", stg_valid, cmp_v);
            for (int i = 0; i < S; i++) check($sformatf("stg_bus[%0d]", i), stg_bus[i*W +: W], m_d[i]);
            check("in_allowin", in_allowin, cmp_f[0] && fl == 0);
            check("out_valid", out_valid, m_v[S-1] && rg[S-1]);
            if (m_v[S-1] && rg[S-1]) check("out_bus", out_bus, m_d[S-1]);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        fl = '0;
        rg = '1;
        out_allowin = 1'b1;
        repeat (8) next_cycle();
    endtask

    task automatic stream_check();
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 8);
            in_bus = c + 1;
            @(negedge clk);
            if (c < 4) begin
                check("stream_out_valid_early", out_valid, 1'b0);
            end else begin
                check("stream_out_valid", out_valid, 1'b1);
                check("stream_out_bus", out_bus, c - 3);
            end
            next_cycle();
        end
        in_valid = 1'b0;
    endtask

    int sent;
    int got;
    logic [31:0] perf_base;

    initial begin
        repeat (2) next_cycle();
        check("reset_stg_valid", stg_valid, '0);
        check("reset_stg_bus", stg_bus, '0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_allowin", in_allowin, 1'b1);
        resetn = 1'b1;
        next_cycle();

        stream_check();
        drain();

        // Downstream back-pressure for 6 cycles mid-stream
        sent = 0;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            out_allowin = !(c >= 6 && c < 12);
            in_valid = (sent < 16);
            in_bus = 32'h100 + sent;
            @(negedge clk);
            if (c == 11) begin
                check("bp_full", stg_valid, 4'hF);
                check("bp_in_allowin", in_allowin, 1'b0);
            end
            if (out_valid && out_allowin) begin
                check("bp_order", out_bus, 32'h100 + got);
                got++;
            end
            if (in_valid && in_allowin) sent++;
            next_cycle();
        end
        check("bp_count", got, 16);
        drain();

        // Stage 1 stalls for 3 cycles with 0x5/0x4 in stages 0/1
        perf_base = '0;
        for (int c = 0; c < 9; c++) begin
            rg = (c >= 5 && c < 8) ? 4'b1101 : 4'b1111;
            in_valid = (c < 8);
            in_bus = (c < 5) ? c + 1 : 6;
            @(negedge clk);
`ifdef PIPE_PERF_CNT_EN
            if (c == 5) perf_base = perf[63:32];
`endif
            if (c >= 5 && c < 8) check("stall_in_allowin", in_allowin, 1'b0);
            if (c == 8) begin
                check("stall_valid", stg_valid, 4'b0011);
                check("stall_stage0", stg_bus[31:0], 32'h5);
                check("stall_stage1", stg_bus[63:32], 32'h4);
`ifdef PIPE_PERF_CNT_EN
                check("stall_perf1", perf[63:32] - perf_base, 32'd3);
`endif
            end
            next_cycle();
        end
        drain();

        // Flush from stage 2 with 0xA..0xD in flight
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 5);
            in_bus = (c < 4) ? 32'hA + c : 32'hE;
            fl = (c == 4) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            if (c == 4) check("flush2_in_allowin", in_allowin, 1'b0);
            if (c == 5) begin
                check("flush2_valid", stg_valid, 4'b1000);
                check("flush2_stage3", stg_bus[127:96], 32'hB);
                check("flush2_stage0_hold", stg_bus[31:0], 32'hD);
            end
            next_cycle();
        end
        drain();

        // Simultaneous flush from stages 3 and 1
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 5);
            in_bus = 32'h20 + c;
            fl = (c == 4) ? 4'b1010 : 4'b0000;
            @(negedge clk);
            if (c == 5) check("flush31_valid", stg_valid, 4'b0000);
            next_cycle();
        end
        drain();

        // Asynchronous reset mid-stream
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_bus = 32'h40 + c;
            next_cycle();
        end
        #2;
        resetn = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_reset_valid", stg_valid, '0);
        check("async_reset_bus", stg_bus, '0);
        check("async_reset_out_valid", out_valid, 1'b0);
        next_cycle();
        resetn = 1'b1;
        next_cycle();
        stream_check();
        drain();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom % 4) != 0;
            in_bus = $urandom;
            for (int i = 0; i < S; i++) rg[i] = ($urandom % 6) != 0;
            out_allowin = ($urandom % 4) != 0;
            fl = (($urandom % 12) == 0) ? 4'($urandom) : 4'b0000;
            next_cycle();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
